// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the bus step controller.
//   state_e            : controller states IDLE, T0..T6, DONE
//   OP_*               : opcode values recognised by the controller
//   IR_*_MSB / IR_*_LSB: bit positions of the opcode and register fields in IR
//   is_alu_op()        : opcode finishes at T5 by loading a general register
//   is_muldiv_op()     : opcode uses the HI/LO pair and needs T6
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_DONE = 4'd8
  } state_e;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR  = 5'b00110;
  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;

  localparam int IR_OP_MSB = 31;
  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_MSB = 26;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_MSB = 22;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_MSB = 18;
  localparam int IR_RC_LSB = 15;

  function automatic logic is_alu_op(input logic [4:0] op);
    logic r;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: r = 1'b1;
      default:                       r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_muldiv_op(input logic [4:0] op);
    logic r;
    case (op)
      OP_MUL, OP_DIV: r = 1'b1;
      default:        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/reg_sel_dec.sv
// 4-to-16 one-hot register select decoder.
//   en  : when 0 the output is all zero
//   sel : register index 0..15
//   dec : one-hot select, bit sel set when enabled
module reg_sel_dec (
  input  logic        en,
  input  logic [3:0]  sel,
  output logic [15:0] dec
);

  // One-hot decode of the register index, gated by enable
  always_comb begin
    dec = 16'h0000;
    if (en) begin
      dec = 16'h0001 << sel;
    end else begin
      dec = 16'h0000;
    end
  end

endmodule

// File: rtl/bus_step_ctrl.sv
// Control-step sequencer for a single-bus datapath: fetch (T0..T2) then
// execute (T3..T6) of one register-to-register instruction per start pulse.
// Optional feature macro: BUS_STEP_MULDIV_EN enables MUL/DIV (T5 loads LO,
// T6 loads HI); without it MUL/DIV decode as illegal.
// Ports:
//   clock, clear_n         : clock, asynchronous active-low reset
//   start                  : begin a sequence (looked at only in IDLE)
//   ir[31:0]               : opcode[31:27] ra[26:23] rb[22:19] rc[18:15]
//   mem_ready              : memory read done, holds the FSM in T1 while low
//   rout_wire[15:0]        : one-hot register bus-source enable
//   hi_out..c_out          : single bus-source enables
//   rin[15:0]              : one-hot register load
//   pc_in..read            : single load / control strobes
//   step, busy, done, illegal : status
// All outputs are decoded combinationally from the state and ir.
module bus_step_ctrl
  import cpu_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        clear_n,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic [15:0] rout_wire,
  output logic        hi_out,
  output logic        lo_out,
  output logic        zhigh_out,
  output logic        zlow_out,
  output logic        pc_out,
  output logic        mdr_out,
  output logic        inport_out,
  output logic        c_out,
  output logic [15:0] rin,
  output logic        pc_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic        inc_pc,
  output logic        read,
  output logic [2:0]  step,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  state_e     state_r;
  logic       first_t1_r;   // high during the first cycle of T1 only
  logic       muldiv_r;     // latched at T3: sequence runs through T6
  logic       illegal_r;    // latched at T3: opcode was rejected
  logic [4:0] op_s;
  logic [3:0] ra_s, rb_s, rc_s;
  logic       muldiv_op_s;
  logic       op_legal_s;
  logic       rout_en_s;
  logic [3:0] rout_sel_s;
  logic       rin_en_s;
  logic       unused_ir_s;

  assign op_s = ir[IR_OP_MSB:IR_OP_LSB];
  assign ra_s = ir[IR_RA_MSB:IR_RA_LSB];
  assign rb_s = ir[IR_RB_MSB:IR_RB_LSB];
  assign rc_s = ir[IR_RC_MSB:IR_RC_LSB];
  assign unused_ir_s = ^ir[14:0];

`ifdef BUS_STEP_MULDIV_EN
  assign muldiv_op_s = is_muldiv_op(op_s);
`else
  assign muldiv_op_s = 1'b0;
`endif

  assign op_legal_s = is_alu_op(op_s) | muldiv_op_s;

  // Register source: rb in T3, rc in T4; illegal T3 drives nothing
  assign rout_en_s  = ((state_r == ST_T3) && op_legal_s) || (state_r == ST_T4);
  assign rout_sel_s = (state_r == ST_T3) ? rb_s : rc_s;
  assign rin_en_s   = (state_r == ST_T5) && !muldiv_r;

  reg_sel_dec u_rout_dec (
    .en  (rout_en_s),
    .sel (rout_sel_s),
    .dec (rout_wire)
  );

  reg_sel_dec u_rin_dec (
    .en  (rin_en_s),
    .sel (ra_s),
    .dec (rin)
  );

  // Step sequencer with opcode classification latched at T3
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_r    <= ST_IDLE;
      first_t1_r <= 1'b0;
      muldiv_r   <= 1'b0;
      illegal_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          muldiv_r  <= 1'b0;
          illegal_r <= 1'b0;
          if (start) begin
            state_r <= ST_T0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_T0: begin
          state_r    <= ST_T1;
          first_t1_r <= 1'b1;
        end
        ST_T1: begin
          first_t1_r <= 1'b0;
          if (mem_ready) begin
            state_r <= ST_T2;
          end else begin
            state_r <= ST_T1;
          end
        end
        ST_T2: state_r <= ST_T3;
        ST_T3: begin
          if (op_legal_s) begin
            muldiv_r <= muldiv_op_s;
            state_r  <= ST_T4;
          end else begin
            illegal_r <= 1'b1;
            state_r   <= ST_DONE;
          end
        end
        ST_T4: state_r <= ST_T5;
        ST_T5: begin
          if (muldiv_r) begin
            state_r <= ST_T6;
          end else begin
            state_r <= ST_DONE;
          end
        end
        ST_T6:   state_r <= ST_DONE;
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Moore decode of single-bit enables and status from the current step
  always_comb begin
    hi_out     = 1'b0;
    lo_out     = 1'b0;
    zhigh_out  = 1'b0;
    zlow_out   = 1'b0;
    pc_out     = 1'b0;
    mdr_out    = 1'b0;
    inport_out = 1'b0;
    c_out      = 1'b0;
    pc_in      = 1'b0;
    mar_in     = 1'b0;
    mdr_in     = 1'b0;
    ir_in      = 1'b0;
    y_in       = 1'b0;
    z_in       = 1'b0;
    hi_in      = 1'b0;
    lo_in      = 1'b0;
    inc_pc     = 1'b0;
    read       = 1'b0;
    step       = 3'd0;
    busy       = 1'b1;
    done       = 1'b0;
    illegal    = 1'b0;
    case (state_r)
      ST_IDLE: busy = 1'b0;
      ST_T0: begin
        step   = 3'd0;
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
      end
      ST_T1: begin
        step     = 3'd1;
        zlow_out = 1'b1;
        read     = 1'b1;
        mdr_in   = 1'b1;
        pc_in    = first_t1_r;
      end
      ST_T2: begin
        step    = 3'd2;
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      ST_T3: begin
        step = 3'd3;
        if (op_legal_s) begin
          y_in = 1'b1;
        end else begin
          y_in = 1'b0;
        end
      end
      ST_T4: begin
        step = 3'd4;
        z_in = 1'b1;
      end
      ST_T5: begin
        step     = 3'd5;
        zlow_out = 1'b1;
        lo_in    = muldiv_r;
      end
      ST_T6: begin
        step      = 3'd6;
        zhigh_out = 1'b1;
        hi_in     = 1'b1;
      end
      ST_DONE: begin
        done    = 1'b1;
        illegal = illegal_r;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_bus_step_ctrl.sv
// Self-checking bench for bus_step_ctrl: a per-cycle expected output list is
// built from the step rules for each instruction and compared against the DUT.
module tb_bus_step_ctrl;
  import cpu_ctrl_pkg::*;

`ifdef BUS_STEP_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        clear_n, start, mem_ready;
  logic [31:0] ir;
  logic [15:0] rout_wire, rin;
  logic hi_out, lo_out, zhigh_out, zlow_out, pc_out, mdr_out, inport_out, c_out;
  logic pc_in, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in, inc_pc, read;
  logic [2:0] step;
  logic busy, done, illegal;

  bus_step_ctrl dut (
    .clock(clock), .clear_n(clear_n), .start(start), .ir(ir), .mem_ready(mem_ready),
    .rout_wire(rout_wire), .hi_out(hi_out), .lo_out(lo_out), .zhigh_out(zhigh_out),
    .zlow_out(zlow_out), .pc_out(pc_out), .mdr_out(mdr_out), .inport_out(inport_out),
    .c_out(c_out), .rin(rin), .pc_in(pc_in), .mar_in(mar_in), .mdr_in(mdr_in),
    .ir_in(ir_in), .y_in(y_in), .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in),
    .inc_pc(inc_pc), .read(read), .step(step), .busy(busy), .done(done),
    .illegal(illegal)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] rout;
    logic hi_out, lo_out, zhigh_out, zlow_out, pc_out, mdr_out, inport_out, c_out;
    logic [15:0] rin;
    logic pc_in, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in, inc_pc, read;
    logic [2:0] step;
    logic busy, done, illegal;
  } outv_t;

  int    checks = 0;
  int    errors = 0;
  outv_t exp_q[$];
  bit    rdy_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic outv_t observed();
    outv_t o;
    o = {rout_wire, hi_out, lo_out, zhigh_out, zlow_out, pc_out, mdr_out, inport_out,
         c_out, rin, pc_in, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in, inc_pc,
         read, step, busy, done, illegal};
    return o;
  endfunction

  function automatic outv_t busy_at(input int s);
    outv_t o;
    o = '0;
    o.step = s[2:0];
    o.busy = 1'b1;
    return o;
  endfunction

  // Expected cycle list, starting at T0, for one instruction
  task automatic build(input logic [31:0] irv, input int waits);
    outv_t o;
    logic [4:0] op;
    bit alu, md;
    op  = irv[31:27];
    alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    md  = MD_EN && ((op == OP_MUL) || (op == OP_DIV));
    exp_q.delete();
    rdy_q.delete();
    o = busy_at(0); o.pc_out = 1'b1; o.mar_in = 1'b1; o.inc_pc = 1'b1; o.z_in = 1'b1;
    exp_q.push_back(o); rdy_q.push_back(1'($urandom_range(0, 1)));
    for (int j = 0; j <= waits; j++) begin
      o = busy_at(1); o.zlow_out = 1'b1; o.read = 1'b1; o.mdr_in = 1'b1;
      o.pc_in = (j == 0);
      exp_q.push_back(o); rdy_q.push_back(j == waits);
    end
    o = busy_at(2); o.mdr_out = 1'b1; o.ir_in = 1'b1;
    exp_q.push_back(o); rdy_q.push_back(1'($urandom_range(0, 1)));
    o = busy_at(3);
    if (alu || md) begin
      o.rout = 16'h0001 << irv[22:19]; o.y_in = 1'b1;
      exp_q.push_back(o); rdy_q.push_back(1'($urandom_range(0, 1)));
      o = busy_at(4); o.rout = 16'h0001 << irv[18:15]; o.z_in = 1'b1;
      exp_q.push_back(o); rdy_q.push_back(1'($urandom_range(0, 1)));
      o = busy_at(5); o.zlow_out = 1'b1;
      if (md) o.lo_in = 1'b1;
      else    o.rin = 16'h0001 << irv[26:23];
      exp_q.push_back(o); rdy_q.push_back(1'($urandom_range(0, 1)));
      if (md) begin
        o = busy_at(6); o.zhigh_out = 1'b1; o.hi_in = 1'b1;
        exp_q.push_back(o); rdy_q.push_back(1'($urandom_range(0, 1)));
      end
    end else begin
      exp_q.push_back(o); rdy_q.push_back(1'($urandom_range(0, 1)));
    end
    o = busy_at(0); o.done = 1'b1; o.illegal = !(alu || md);
    exp_q.push_back(o); rdy_q.push_back(1'($urandom_range(0, 1)));
  endtask

  function automatic logic srcs_ok();
    return $countones({rout_wire, hi_out, lo_out, zhigh_out, zlow_out, pc_out, mdr_out,
                       inport_out, c_out}) <= 1;
  endfunction

  // Apply start in IDLE; returns #1 after the edge that enters T0
  task automatic launch(input logic [31:0] irv);
    @(negedge clock);
    ir = irv;
    start = 1'b1;
    mem_ready = 1'($urandom_range(0, 1));
    @(posedge clock); #1;
  endtask

  // Check cycles from..n-1 of exp_q; finishing the list also checks return to IDLE
  task automatic walk(input string tag, input int from, input int n);
    for (int k = from; k < n; k++) begin
      mem_ready = rdy_q[k];
      start = (k == exp_q.size() - 1) ? 1'b0 : 1'($urandom_range(0, 1));
      check($sformatf("%s_c%0d", tag, k), 64'(observed()), 64'(exp_q[k]));
      check($sformatf("%s_onehot%0d", tag, k), 64'(srcs_ok()), 64'd1);
      @(posedge clock); #1;
    end
    if (n == exp_q.size()) check($sformatf("%s_idle", tag), 64'(observed()), 64'd0);
  endtask

  task automatic run_seq(input string tag, input logic [31:0] irv, input int waits);
    build(irv, waits);
    launch(irv);
    walk(tag, 0, exp_q.size());
  endtask

  // Reset asynchronously in cycle stop_k, then restart right on release
  task automatic reset_mid(input string tag, input logic [31:0] irv, input int waits,
                           input int stop_k);
    build(irv, waits);
    launch(irv);
    walk(tag, 0, stop_k);
    check({tag, "_pre"}, 64'(observed()), 64'(exp_q[stop_k]));
    #2 clear_n = 1'b0;
    #1 check({tag, "_rst"}, 64'(observed()), 64'd0);
    @(negedge clock);
    check({tag, "_rst_hold"}, 64'(observed()), 64'd0);
    build(irv, waits);
    ir = irv;
    start = 1'b1;
    clear_n = 1'b1;
    @(posedge clock); #1;
    walk({tag, "_re"}, 0, exp_q.size());
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    logic [31:0] v;
    v = $urandom;
    v[31:27] = op; v[26:23] = ra; v[22:19] = rb; v[18:15] = rc;
    return v;
  endfunction

  initial begin
    logic [4:0] ops[6];
    logic [4:0] op;
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_DIV};
    clear_n = 1'b0; start = 1'b1; mem_ready = 1'b1; ir = mk_ir(OP_ADD, 4'd1, 4'd2, 4'd3);
    repeat (2) @(posedge clock);
    #1 check("reset_state", 64'(observed()), 64'd0);
    @(negedge clock);
    start = 1'b0; clear_n = 1'b1;
    @(posedge clock); #1 check("idle_no_start", 64'(observed()), 64'd0);

    run_seq("add_basic", mk_ir(OP_ADD, 4'd3, 4'd1, 4'd2), 0);
    run_seq("t1_wait3", mk_ir(OP_SUB, 4'd5, 4'd6, 4'd7), 3);
    run_seq("mul", mk_ir(OP_MUL, 4'd4, 4'd8, 4'd9), 0);
    run_seq("div", mk_ir(OP_DIV, 4'd0, 4'd15, 4'd15), 1);
    run_seq("op_1f", mk_ir(5'b11111, 4'd2, 4'd3, 4'd4), 0);
    run_seq("rb_eq_rc", mk_ir(OP_OR, 4'd9, 4'd9, 4'd9), 0);
    run_seq("edge_regs", mk_ir(OP_AND, 4'd15, 4'd0, 4'd15), 2);
    reset_mid("rst_t4", mk_ir(OP_ADD, 4'd3, 4'd1, 4'd2), 0, 4);
    reset_mid("rst_t1wait", mk_ir(OP_ADD, 4'd6, 4'd11, 4'd12), 3, 2);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 4) == 0) op = 5'($urandom);
      else                           op = ops[$urandom_range(0, 5)];
      run_seq($sformatf("rnd%0d", i),
              mk_ir(op, 4'($urandom), 4'($urandom), 4'($urandom)), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_step_ctrl.md
BUS_STEP_CTRL -- requirements
Module: bus_step_ctrl

Interface
REQ-001 SHALL have ports: clock  in  1  single system clock, all state on rising edge.
REQ-002 SHALL have ports: clear_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: start  in  1  begin one instruction sequence, sampled only in IDLE.
REQ-004 SHALL have ports: ir  in  32  current IR contents: opcode[31:27], ra[26:23], rb[22:19], rc[18:15].
REQ-005 SHALL have ports: mem_ready  in  1  memory read complete, sampled in T1.
REQ-006 SHALL have ports: rout_wire  out  16  one-hot R0out..R15out to bus encoder.
REQ-007 SHALL have ports: hi_out, lo_out, zhigh_out, zlow_out, pc_out, mdr_out, inport_out, c_out  out  1 each  bus-source enables.
REQ-008 SHALL have ports: rin  out  16  one-hot register load; pc_in, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in, inc_pc, read  out  1 each.
REQ-009 SHALL have ports: step  out  3  current T-step index; busy, done, illegal  out  1 each.

Function
REQ-010 SHALL implement FSM states IDLE, T0..T6, DONE; step = T index, 0 in IDLE/DONE.
REQ-011 IDLE -> T0 when start=1; start ignored in all other states.
REQ-012 T0: pc_out, mar_in, inc_pc, z_in asserted.
REQ-013 T1: zlow_out, pc_in, read, mdr_in asserted; FSM stays in T1 while mem_ready=0; pc_in asserted only on first T1 cycle.
REQ-014 T2: mdr_out, ir_in asserted.
REQ-015 T3: rout_wire[rb] and y_in asserted.
REQ-016 T4: rout_wire[rc] and z_in asserted.
REQ-017 T5: zlow_out plus rin[ra] (ALU ops) or lo_in (MUL/DIV).
REQ-018 T6: reached only for MUL/DIV; zhigh_out, hi_in asserted.
REQ-019 DONE held exactly one cycle with done=1, then IDLE.
REQ-020 Opcode decoded at T3 from ir; opcode not in the package table -> illegal=1 for the DONE cycle, FSM goes T3 -> DONE with no source driven in T3.
REQ-021 At most one bus-source output (rout_wire bits plus the eight single enables) SHALL be 1 in any cycle; all zero in IDLE, DONE, illegal T3.
REQ-022 rb=rc permitted: same rout_wire bit in T3 and T4; ra=rb permitted.
REQ-023 busy=1 in T0..T6 and DONE, 0 in IDLE.
REQ-024 All outputs combinational from state and ir (Moore plus ir field decode); no added latency.

Reset
REQ-025 clear_n=0 SHALL force IDLE immediately, all outputs 0, including mid-sequence and during T1 wait.
REQ-026 First start is accepted on the first rising edge after clear_n deasserts.

Configuration
REQ-027 Macro BUS_STEP_MULDIV_EN defined: MUL/DIV opcodes are legal and follow T0..T6.
REQ-028 Macro undefined: MUL/DIV opcodes are illegal per REQ-020; T6, hi_in, lo_in, zhigh_out stay 0 always.

Structure
REQ-029 Shared package cpu_ctrl_pkg SHALL hold the state enum, opcode constants (ADD, SUB, AND, OR, MUL, DIV) and the IR field bit positions.
REQ-030 Sub-module reg_sel_dec (4-to-16 one-hot decoder with enable) SHALL be instantiated for rout_wire and rin.

Verification
REQ-031 ADD, ra=3 rb=1 rc=2, mem_ready=1 -> steps 0..5; T3 rout_wire=0x0002, T4 0x0004, T5 rin=0x0008; done pulses at cycle 7.
REQ-032 mem_ready low 3 cycles in T1 -> step=1 for 4 cycles; pc_in high only in first; read held throughout.
REQ-033 MUL with BUS_STEP_MULDIV_EN -> T5 lo_in, T6 zhigh_out+hi_in; without macro -> illegal=1, no T4..T6.
REQ-034 Opcode 5'b11111 -> illegal=1 in DONE, rout_wire=0 at T3.
REQ-035 clear_n pulled low in T4 -> all outputs 0 immediately; restart with start=1 begins at T0.
REQ-036 Every cycle of random legal sequences: one-hot-or-zero check on all bus-source outputs.
